// File: rtl/eop_skew_monitor.sv
// Windowed sampling monitor for the two_chains inverter pair.
// Counts XOR-high, A/B mismatch and A-transition cycles, holding results for readout.
module eop_skew_monitor #(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             output_A,
  input  logic             output_B,
  input  logic             output_XOR,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] xor_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] a_edge_count,
  output logic             saturated
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [SYNC_STAGES-1:0] r_sync_x;
  logic                   r_a_prev;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [WIN_W-1:0] r_win_cnt;

  logic [CNT_W-1:0] r_xor_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic             r_valid;

  logic w_a_s;
  logic w_b_s;
  logic w_x_s;
  logic w_accept;
  logic w_counting;
  logic w_win_end;
  logic w_xor_inc;
  logic w_mis_inc;
  logic w_edge_inc;
  logic w_xor_full;
  logic w_mis_full;
  logic w_edge_full;
  logic w_overflow;

  assign w_a_s = r_sync_a[SYNC_STAGES-1];
  assign w_b_s = r_sync_b[SYNC_STAGES-1];
  assign w_x_s = r_sync_x[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_sync_x <= '0;
      r_a_prev <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], output_A};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], output_B};
      r_sync_x <= {r_sync_x[SYNC_STAGES-2:0], output_XOR};
      r_a_prev <= w_a_s;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && start;
  // The extra COUNT cycle at win_cnt == WINDOW only hands over to DONE.
  assign w_win_end  = (r_win_cnt == WIN_LAST);
  assign w_counting = (r_state == S_COUNT) && !w_win_end;

  assign w_xor_inc  = w_counting && w_x_s;
  assign w_mis_inc  = w_counting && (w_a_s ^ w_b_s);
  assign w_edge_inc = w_counting && (w_a_s ^ r_a_prev);

  assign w_xor_full  = (r_xor_cnt == CNT_MAX);
  assign w_mis_full  = (r_mis_cnt == CNT_MAX);
  assign w_edge_full = (r_edge_cnt == CNT_MAX);

  assign w_overflow = (w_xor_inc && w_xor_full)
                   || (w_mis_inc && w_mis_full)
                   || (w_edge_inc && w_edge_full);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ARM;
      S_ARM:   if (r_arm_cnt == ARM_LAST) w_next = S_COUNT;
      S_COUNT: if (w_win_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_arm_cnt <= '0;
    end else if (w_accept) begin
      r_arm_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_win_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_win_cnt <= '0;
    end else if (w_counting) begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_xor_cnt <= '0;
    end else if (w_accept) begin
      r_xor_cnt <= '0;
    end else if (w_xor_inc && !w_xor_full) begin
      r_xor_cnt <= r_xor_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_mis_cnt <= '0;
    end else if (w_accept) begin
      r_mis_cnt <= '0;
    end else if (w_mis_inc && !w_mis_full) begin
      r_mis_cnt <= r_mis_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_edge_cnt <= '0;
    end else if (w_accept) begin
      r_edge_cnt <= '0;
    end else if (w_edge_inc && !w_edge_full) begin
      r_edge_cnt <= r_edge_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= 1'b0;
    end else if (w_overflow) begin
      r_sat <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end else if ((r_state == S_COUNT) && w_win_end) begin
      r_valid <= 1'b1;
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign result_valid   = r_valid;
  assign xor_count      = r_xor_cnt;
  assign mismatch_count = r_mis_cnt;
  assign a_edge_count   = r_edge_cnt;
  assign saturated      = r_sat;

endmodule

// File: tb/tb_eop_skew_monitor.sv
// Scoreboard bench for eop_skew_monitor: wide and 3-bit-counter instances share stimulus.
// Expected counts come from summing the sampled input vectors of each run.
module tb_eop_skew_monitor;

  localparam int W = 8;
  localparam int S = 2;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic start = 1'b0;
  logic output_A = 1'b0;
  logic output_B = 1'b0;
  logic output_XOR = 1'b0;

  logic busy16, rv16, sat16;
  logic [15:0] x16, m16, e16;
  logic busy3, rv3, sat3;
  logic [2:0] x3, m3, e3;

  eop_skew_monitor #(.CNT_W(16), .WINDOW(W), .SYNC_STAGES(S)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .output_A(output_A), .output_B(output_B), .output_XOR(output_XOR),
    .busy(busy16), .result_valid(rv16),
    .xor_count(x16), .mismatch_count(m16), .a_edge_count(e16),
    .saturated(sat16)
  );

  eop_skew_monitor #(.CNT_W(3), .WINDOW(W), .SYNC_STAGES(S)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .output_A(output_A), .output_B(output_B), .output_XOR(output_XOR),
    .busy(busy3), .result_valid(rv3),
    .xor_count(x3), .mismatch_count(m3), .a_edge_count(e3),
    .saturated(sat3)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int rv_cyc;
    int xc;
    int mc;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  bit a_v [0:W];
  bit b_v [0:W];
  bit x_v [0:W];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i <= W; i++) begin
      case (mode)
        0: begin a_v[i] = 0; b_v[i] = 0; x_v[i] = 0; end
        1: begin a_v[i] = i[0]; b_v[i] = i[0]; x_v[i] = 0; end
        2: begin a_v[i] = 1; b_v[i] = 0; x_v[i] = 1; end
        3: begin a_v[i] = 0; b_v[i] = 0; x_v[i] = (i >= 1 && i <= 5); end
        default: begin
          a_v[i] = 1'($urandom_range(1));
          b_v[i] = 1'($urandom_range(1));
          x_v[i] = 1'($urandom_range(1));
        end
      endcase
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_rv"}, rv16, 0);
    chk({tag, "_xor"}, x16, 0);
    chk({tag, "_mis"}, m16, 0);
    chk({tag, "_edge"}, e16, 0);
    chk({tag, "_sat"}, sat16, 0);
    chk({tag, "_rv3"}, rv3, 0);
    chk({tag, "_xor3"}, x3, 0);
    chk({tag, "_sat3"}, sat3, 0);
  endtask

  // Samples taken at edges k..k+W; count edges see samples 1..W.
  task automatic run(input int extra_at, input bit hold);
    int k;
    exp_t e;
    @(negedge sys_clk);
    k = cyc + 1;
    e.rv_cyc = k + S + W + 1;
    e.xc = 0;
    e.mc = 0;
    e.ec = 0;
    for (int i = 1; i <= W; i++) begin
      e.xc += int'(x_v[i]);
      e.mc += int'(a_v[i] ^ b_v[i]);
      e.ec += int'(a_v[i] ^ a_v[i-1]);
    end
    exp_q.push_back(e);
    for (int i = 0; i <= W; i++) begin
      start = hold || (i == 0) || (i == extra_at);
      output_A = a_v[i];
      output_B = b_v[i];
      output_XOR = x_v[i];
      if (i == 0) begin
        @(posedge sys_clk);
        #1;
        chk("accept_busy", busy16, 1);
        chk("accept_rv", rv16, 0);
        chk("accept_xor", x16, 0);
        chk("accept_mis", m16, 0);
        chk("accept_edge", e16, 0);
        chk("accept_sat3", sat3, 0);
      end
      @(negedge sys_clk);
    end
    if (hold) begin
      e.rv_cyc = (k + S + W + 3) + S + W + 1;
      e.xc = W * int'(x_v[W]);
      e.mc = W * int'(a_v[W] ^ b_v[W]);
      e.ec = 0;
      exp_q.push_back(e);
      repeat (5) @(negedge sys_clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 60; t++) begin
      @(negedge sys_clk);
      if (!busy16) break;
    end
    if (t == 60) chk("idle_timeout", 1, 0);
  endtask

  initial begin : monitor
    bit rv_d;
    int pend;
    exp_t e;
    rv_d = 0;
    pend = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (pend != 0) begin
        chk("busy_fall", busy16, 0);
        chk("busy_fall3", busy3, 0);
        pend = 0;
      end
      if (rv16 && !rv_d) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rv_cycle", cyc, e.rv_cyc);
          chk("busy_done", busy16, 1);
          chk("rv3_sync", rv3, 1);
          chk("xor16", x16, e.xc);
          chk("mis16", m16, e.mc);
          chk("edge16", e16, e.ec);
          chk("sat16", sat16, (e.xc > 65535 || e.mc > 65535 || e.ec > 65535) ? 1 : 0);
          chk("xor3", x3, clip(e.xc, 7));
          chk("mis3", m3, clip(e.mc, 7));
          chk("edge3", e3, clip(e.ec, 7));
          chk("sat3", sat3, (e.xc > 7 || e.mc > 7 || e.ec > 7) ? 1 : 0);
          pend = 1;
        end
      end
      rv_d = rv16;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    #1;
    chk_zero("reset");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    fill(0); run(-1, 0); wait_idle();
    fill(1); run(-1, 0); wait_idle();
    fill(2); run(-1, 0); wait_idle();
    fill(3); run(-1, 0); wait_idle();
    fill(0); run(-1, 0); wait_idle();

    for (int r = 0; r < 12; r++) begin
      fill(4);
      run(int'($urandom_range(W, 1)), 0);
      wait_idle();
    end

    fill(4); run(-1, 1); wait_idle();
    repeat (2) @(negedge sys_clk);

    // Run aborted by reset, with a stray start inside COUNT.
    output_A = 1'b1;
    output_B = 1'b0;
    output_XOR = 1'b1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (S + 3) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("pre_reset_xor", (x16 != 0) ? 1 : 0, 1);
    #1 sys_rst = 1'b1;
    #1 chk_zero("abort");
    #1 sys_rst = 1'b0;
    for (int i = 0; i < S + W + 4; i++) begin
      @(negedge sys_clk);
      chk("post_abort_busy", busy16, 0);
      chk("post_abort_rv", rv16, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
